// File: rtl/multi_pwm_if.sv
// rtl/multi_pwm_if.sv - control and drive bundle for the multi-channel PWM
interface multi_pwm_if #(
  parameter int N        = 8,
  parameter int CHANNELS = 4
);
  logic                     step;
  logic [CHANNELS-1:0]      ena;
  logic [CHANNELS*N-1:0]    duty;
  logic [N-1:0]             top;
  logic                     center;
  logic [CHANNELS-1:0]      out;
  logic                     period_start;

  modport master (
    output step, ena, duty, top, center,
    input  out, period_start
  );

  modport slave (
    input  step, ena, duty, top, center,
    output out, period_start
  );
endinterface

// File: rtl/multi_pwm.sv
// rtl/multi_pwm.sv - shared-counter PWM with shadowed duty/top/mode and per-channel polarity
module multi_pwm #(
  parameter int                  N        = 8,
  parameter int                  CHANNELS = 4,
  parameter logic [CHANNELS-1:0] POLARITY = {CHANNELS{1'b0}}
) (
  input logic          clk,
  input logic          rst,
  multi_pwm_if.slave   bus
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0]        cnt;
  logic [N-1:0]        cnt_nxt;
  logic                dir;
  logic                dir_nxt;
  logic                boundary;
  logic [N-1:0]        act_duty [CHANNELS];
  logic [N-1:0]        act_top;
  logic                act_center;
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] out_q;
  logic                period_start_q;

  // Next counter value and direction for a step, for both counting modes
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (!act_center) begin
      cnt_nxt = (cnt == act_top) ? '0 : cnt + ONE;
      dir_nxt = 1'b0;
    end else if (act_top == '0) begin
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end else if (!dir) begin
      if (cnt < act_top) begin
        cnt_nxt = cnt + ONE;
      end else begin
        // Turn around at the peak; with top=1 the turn lands on 0 so stay up
        cnt_nxt = act_top - ONE;
        dir_nxt = (act_top != ONE);
      end
    end else begin
      if (cnt > ONE) begin
        cnt_nxt = cnt - ONE;
      end else begin
        cnt_nxt = '0;
        dir_nxt = 1'b0;
      end
    end
    boundary = bus.step && (cnt_nxt == '0);
  end

  // Per-channel compare against the active (shadow-loaded) duty and top
  always_comb begin
    raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw[i] = (act_duty[i] != '0) &&
               ((cnt < act_duty[i]) || (act_duty[i] >= act_top));
    end
  end

  // Shadow registers: captured in reset and on every boundary step only
  always_ff @(posedge clk) begin
    if (!rst || boundary) begin
      for (int i = 0; i < CHANNELS; i++) begin
        act_duty[i] <= bus.duty[i*N +: N];
      end
      act_top    <= bus.top;
      act_center <= bus.center;
    end
  end

  // Counter, direction, registered outputs and period strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt            <= '0;
      dir            <= 1'b0;
      out_q          <= POLARITY;
      period_start_q <= 1'b0;
    end else begin
      if (bus.step) begin
        cnt <= cnt_nxt;
        dir <= boundary ? 1'b0 : dir_nxt;
      end
      period_start_q <= boundary;
      out_q          <= (bus.ena & (raw ^ POLARITY)) | (~bus.ena & POLARITY);
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_multi_pwm.sv
// tb/tb_multi_pwm.sv - scoreboard bench for multi_pwm with directed hand-computed vectors
module tb_multi_pwm;

  typedef struct {
    int         cyc;
    logic [3:0] out;
    logic       ps;
    int         tid;
    int         k;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  exp_t q[$];
  exp_t e;

  logic [3:0] pa  [0:9];
  logic [3:0] pb  [0:9];
  logic       psp [0:9];
  logic       stp [0:9];
  int         per;
  int         chg_k;
  int         sw_k;
  logic [31:0] chg_duty;
  logic [3:0]  chg_ena;

  multi_pwm_if #(.N(8), .CHANNELS(4)) bus ();

  multi_pwm #(.N(8), .CHANNELS(4), .POLARITY(4'b0010)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expectation due at this cycle and compare
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (bus.out === e.out) passes++;
      else $display("FAIL out t%0d k%0d got %b want %b", e.tid, e.k, bus.out, e.out);
      checks++;
      if (bus.period_start === e.ps) passes++;
      else $display("FAIL period_start t%0d k%0d got %b want %b", e.tid, e.k, bus.period_start, e.ps);
    end
  end

  task automatic push(input int c, input logic [3:0] o, input logic p, input int tid, input int k);
    exp_t x;
    x.cyc = c; x.out = o; x.ps = p; x.tid = tid; x.k = k;
    q.push_back(x);
  endtask

  task automatic defaults();
    for (int p = 0; p < 10; p++) begin
      pa[p] = 4'b0000; pb[p] = 4'b0000; psp[p] = 1'b0; stp[p] = 1'b1;
    end
    chg_k = 0;
    sw_k  = 1000;
  endtask

  // Two reset edges with the test's values applied, then n stepped edges
  task automatic run_test(input int tid, input int n, input logic [31:0] duties,
                          input logic [7:0] t, input logic c, input logic [3:0] en);
    int p;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.duty = duties; bus.top = t; bus.center = c; bus.ena = en; bus.step = 1'b1;
      push(cyc + 1, 4'b0010, 1'b0, tid, -r);
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      rst = 1'b1;
      p = (k - 1) % per;
      if (k == chg_k) begin
        bus.duty = chg_duty;
        bus.ena  = chg_ena;
      end
      bus.step = stp[p];
      push(cyc + 1, (k >= sw_k) ? pb[p] : pa[p], psp[p], tid, k);
    end
  endtask

  initial begin
    bus.step = 1'b0; bus.ena = '0; bus.duty = '0; bus.top = '0; bus.center = 1'b0;
    chg_duty = '0; chg_ena = '0; per = 1;

    // T1 edge top=9: ch0 duty3, ch1 duty3 inverted, ch2 duty0, ch3 duty=top
    defaults(); per = 10;
    for (int p = 0; p < 10; p++) pa[p] = (p < 3) ? 4'b1001 : 4'b1010;
    psp[9] = 1'b1;
    run_test(1, 26, {8'd9, 8'd0, 8'd3, 8'd3}, 8'd9, 1'b0, 4'hf);

    // T2 reset at cnt=6, then duty0 3->7 at cnt=5, visible from next period
    defaults(); per = 10;
    pa[0] = 4'b1001; pa[1] = 4'b1001; pa[2] = 4'b1001; pa[3] = 4'b1000; pa[4] = 4'b1000;
    for (int p = 5; p < 10; p++) pa[p] = 4'b1010;
    pb[0] = 4'b1001; pb[1] = 4'b1001; pb[2] = 4'b1001; pb[3] = 4'b1001; pb[4] = 4'b1001;
    pb[5] = 4'b1011; pb[6] = 4'b1011; pb[7] = 4'b1010; pb[8] = 4'b1010; pb[9] = 4'b1010;
    psp[9] = 1'b1;
    chg_k = 6; chg_duty = {8'd9, 8'd0, 8'd5, 8'd7}; chg_ena = 4'hf; sw_k = 11;
    run_test(2, 30, {8'd9, 8'd0, 8'd5, 8'd3}, 8'd9, 1'b0, 4'hf);

    // T3 center top=4: counts 0,1,2,3,4,3,2,1
    defaults(); per = 8;
    pa[0] = 4'b1101; pa[1] = 4'b1001; pa[2] = 4'b1011; pa[3] = 4'b0011;
    pa[4] = 4'b0011; pa[5] = 4'b0011; pa[6] = 4'b1011; pa[7] = 4'b1001;
    psp[7] = 1'b1;
    run_test(3, 24, {8'd3, 8'd1, 8'd2, 8'd4}, 8'd4, 1'b1, 4'hf);

    // T4 top=0: every step is a boundary, duty1 always on
    defaults(); per = 1;
    pa[0] = 4'b0111; psp[0] = 1'b1;
    run_test(4, 6, {8'd0, 8'd5, 8'd0, 8'd1}, 8'd0, 1'b1, 4'hf);

    // T5 ch1 disabled idles at 1, duty 255 > top; ena[1] set mid-period acts at once
    defaults(); per = 10;
    for (int p = 0; p < 10; p++) begin
      pa[p] = (p < 3) ? 4'b1111 : 4'b1010;
      pb[p] = (p < 3) ? 4'b1101 : 4'b1010;
    end
    psp[9] = 1'b1;
    chg_k = 13; chg_duty = {8'd255, 8'd3, 8'd3, 8'd3}; chg_ena = 4'hf; sw_k = 13;
    run_test(5, 25, {8'd255, 8'd3, 8'd3, 8'd3}, 8'd9, 1'b0, 4'b1101);

    // T6 edge top=3 with step only every other cycle: counter holds between steps
    defaults(); per = 8;
    pa[0] = 4'b0101; pa[1] = 4'b0111; pa[2] = 4'b0111; pa[3] = 4'b0110;
    pa[4] = 4'b0110; pa[5] = 4'b0110; pa[6] = 4'b0110; pa[7] = 4'b0101;
    psp[6] = 1'b1;
    for (int p = 0; p < 8; p++) stp[p] = (p % 2 == 0);
    run_test(6, 16, {8'd0, 8'd3, 8'd1, 8'd2}, 8'd3, 1'b0, 4'hf);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain got %0d pending want 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multi_pwm.md
# multi_pwm

Multi-channel, parametrised PWM generator replacing the single-channel counter-compare PWM. One shared period counter drives CHANNELS independent compare channels. It adds:
- a programmable period (top);
- edge-aligned or center-aligned counting;
- shadowed duty, top and mode values that only take effect at period boundaries (glitch-free updates);
- per-channel output polarity;
- a period-start strobe.

It sits between the register/control logic and the motor/LED/amp drive pins. A shared prescaler feeds its step input.

## Interface
Parameters:
- N, 8, counter, top and duty width in bits.
- CHANNELS, 4, number of compare channels.
- POLARITY, {CHANNELS{1'b0}}, per-channel bit. 1 inverts that channel's output; its inactive/idle level becomes 1.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  one clock; reset is synchronous and active-low.
- step  input  1  counter advance enable. The counter moves only on cycles with step=1.
- ena  input  CHANNELS  per-channel output enable.
- duty  input  CHANNELS*N  duty requests. Channel i occupies [i*N +: N]. Shadowed.
- top  input  N  period limit. Shadowed.
- center  input  1  mode request: 0 = edge-aligned, 1 = center-aligned. Shadowed.
- out  output  CHANNELS  registered PWM outputs.
- period_start  output  1  registered one-clk strobe, high the cycle after a boundary step.

## Operation
- Active registers:
  - act_duty[i], act_top, act_center.
  - Internal counter cnt (N bits) and direction flag dir (0 = up).
- Reset (rst=0 at a clock edge):
  - cnt=0, dir=0.
  - act_duty/act_top/act_center load directly from the duty/top/center inputs.
  - out=POLARITY, period_start=0.
- Edge mode, step=1:
  - cnt==act_top → cnt=0.
  - Otherwise cnt+1.
  - Period = act_top+1 steps.
- Center mode, step=1:
  - act_top==0 → cnt stays 0.
  - Up and cnt<act_top → cnt+1.
  - Up and cnt==act_top → cnt=act_top-1; dir=1 unless that value is 0.
  - Down and cnt>1 → cnt-1.
  - Down and cnt==1 → cnt=0, dir=0.
  - Sequence is 0,1..top,top-1..1; period = 2*act_top steps (1 step when top=0).
- Boundary step: a step=1 cycle whose next cnt is 0.
  - Including the top=0 case, where every step is a boundary.
  - On that same edge, act_* load from the inputs, dir=0, and period_start is set for one cycle.
- Shadowing: duty/top/center changes between boundaries are invisible to the outputs. Only the values present on the boundary clock edge are used.
- Compare per channel, using current cnt and act_*:
  - raw[i] = (act_duty[i]!=0) & ((cnt < act_duty[i]) | (act_duty[i] >= act_top)).
  - duty=0 → never on.
  - duty>=top → always on.
  - Otherwise on for counts below duty (duty of top+1 slots in edge mode).
- Output: out[i] <= ena[i] ? raw[i]^POLARITY[i] : POLARITY[i].
- Arithmetic: unsigned, N bits, no wrap beyond act_top. Top, duty and cnt compare at full N width.

## Timing
- out and period_start are registered. The value in cycle t+1 reflects cnt/act_*/ena in cycle t.
- A step at edge t changes cnt at t. The resulting out change is visible after edge t+1 (1-cycle latency).
- ena has 1-cycle latency and is not shadowed; it acts immediately, even mid-period.
- A new duty/top/center affects out exactly 1 cycle after the boundary edge that loads it.
- step=0: cnt, dir and act_* hold. out keeps tracking ena/raw.
- Simultaneous input change and boundary step: the new values are captured on that edge.
- Reset mid-period: the next cycle has cnt=0 and out=POLARITY; counting restarts at 0 with the values present during reset.
- Mode change takes effect only at a boundary, always starting from cnt=0, dir up.

## Test plan
- Edge mode, N=8, top=9, duty0=3, ena=1, step=1 continuously → out[0] high 3 of every 10 clks; period_start pulses every 10 clks.
- Center mode, top=4, duty1=2 → cnt runs 0,1,2,3,4,3,2,1; out[1] high at counts 0,1,1 (3 of 8); period_start every 8 clks.
- Boundaries: duty=0 → out stays 0. duty=top=9 → out stays 1. duty=255 with top=9 → stays 1. top=0 with duty=1 → constant 1 with period_start every step.
- Shadow: change duty0 from 3 to 7 at cnt=5 → remainder of that period still uses 3; next period shows 7 high clks, starting 1 clk after the boundary.
- POLARITY=4'b0010, ena[1]=0 → out[1]=1. Set ena[1]=1 with duty=3, top=9 → out[1] low 3 of 10 clks.
- Assert rst=0 at cnt=6 for 2 clks with step=1 → out=POLARITY, period_start=0. After release, cnt counts from 0 using the values sampled during reset.
